// File: rtl/capture_seq_if.sv
// capture_seq_if: valid/ready sample stream between FIFO, sequencer and DMA
//   tdata   sample word
//   tvalid  producer has a word
//   tready  consumer accepts the word
//   tlast   final beat of a transfer (driven by the sequencer towards DMA)
interface capture_seq_if #(parameter int size = 32);
    logic [size-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/capture_seq.sv
// capture_seq: sequences arm/trigger/done of the capture engine and gates the FIFO stream to DMA
//   clk, reset (async, active-low)
//   start/stop       software start and abort requests, buffer_size latched on accepted start
//   cap_*            arm/abort pulses out, armed/triggered/done/ready status in
//   s                FIFO stream in, m DMA stream out (tlast on the buffer's final beat)
//   busy, done_irq, result (0 none, 1 ok, 2 aborted, 3 error), beat_count
module capture_seq #(
    parameter int size      = 32,
    parameter int saddr_w   = 24,
    parameter int timeout_w = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [saddr_w-1:0] buffer_size,
    output logic               cap_arm,
    output logic               cap_abort,
    input  logic               cap_armed,
    input  logic               cap_triggered,
    input  logic               cap_done,
    input  logic               cap_ready,
    capture_seq_if.slave       s,
    capture_seq_if.master      m,
    output logic               busy,
    output logic               done_irq,
    output logic [1:0]         result,
    output logic [saddr_w-1:0] beat_count
);
    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_ARMED, WAIT_TRIG, WAIT_DONE, DRAIN, FINISH, ABORT, FLUSH
    } state_t;
    state_t state, state_d;
    logic [saddr_w-1:0]   len_q;
    logic [timeout_w-1:0] tcnt;
    logic [1:0]           pend, pend_d;
    logic pass, beat, last_beat, go, err, flush_exit;
    assign pass       = state inside {WAIT_TRIG, WAIT_DONE, DRAIN};
    assign m.tdata    = size'(s.tdata);
    assign m.tvalid   = s.tvalid & pass;
    assign s.tready   = (m.tready & pass) | (state == FLUSH);
    assign m.tlast    = pass & (beat_count == len_q - saddr_w'(1));
    assign beat       = s.tvalid & s.tready & pass;
    assign last_beat  = beat & m.tlast;
    assign go         = state == IDLE && start && !stop && cap_ready && buffer_size != '0;
    assign err        = state == IDLE && start && !stop && cap_ready && buffer_size == '0;
    assign flush_exit = state == FLUSH && cap_ready && !s.tvalid;
    always_comb begin
        state_d = state;
        pend_d  = pend;
        case (state)
            IDLE:       state_d = go ? ARM : IDLE;
            ARM:        state_d = WAIT_ARMED;
            // counter is at 2^timeout_w-2 on the last waiting cycle, so the abort lands at all-ones
            WAIT_ARMED: if (cap_armed) state_d = WAIT_TRIG;
                        else if (tcnt == ~timeout_w'(1)) begin
                            state_d = ABORT;
                            pend_d  = 2'd3;
                        end
            WAIT_TRIG:  state_d = last_beat ? FINISH : cap_triggered ? WAIT_DONE : WAIT_TRIG;
            WAIT_DONE:  state_d = last_beat ? FINISH : cap_done ? DRAIN : WAIT_DONE;
            DRAIN:      state_d = last_beat ? FINISH : DRAIN;
            FINISH:     state_d = IDLE;
            ABORT:      state_d = FLUSH;
            FLUSH:      state_d = flush_exit ? IDLE : FLUSH;
            default:    state_d = IDLE;
        endcase
        // a stop colliding with the final beat lets the transfer complete
        if (stop && !last_beat && state inside {ARM, WAIT_ARMED, WAIT_TRIG, WAIT_DONE, DRAIN}) begin
            state_d = ABORT;
            pend_d  = 2'd2;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pend       <= '0;
            len_q      <= '0;
            tcnt       <= '0;
            beat_count <= '0;
            cap_arm    <= 1'b0;
            cap_abort  <= 1'b0;
            busy       <= 1'b0;
            done_irq   <= 1'b0;
            result     <= '0;
        end else begin
            state      <= state_d;
            pend       <= pend_d;
            len_q      <= go ? buffer_size : len_q;
            tcnt       <= state == WAIT_ARMED ? tcnt + timeout_w'(1) : '0;
            beat_count <= go ? '0 : beat_count + saddr_w'(beat);
            cap_arm    <= state_d == ARM;
            cap_abort  <= state_d == ABORT;
            busy       <= state_d != IDLE;
            done_irq   <= state_d == FINISH || flush_exit || err;
            result     <= state_d == FINISH ? 2'd1 : flush_exit ? pend : err ? 2'd3 : go ? 2'd0 : result;
        end
    end
endmodule

// File: tb/tb_capture_seq.sv
// tb_capture_seq: command table, directed corner sequences and randomized transfers against a stream model
module tb_capture_seq;
    localparam int size = 32, saddr_w = 24, timeout_w = 4;
    logic clk = 0, reset = 0, start = 0, stop = 0;
    logic [saddr_w-1:0] buffer_size = '0;
    logic cap_arm, cap_abort, busy, done_irq;
    logic cap_armed = 0, cap_triggered = 0, cap_done = 0, cap_ready = 1;
    logic [1:0] result;
    logic [saddr_w-1:0] beat_count;
    int checks = 0, errors = 0;
    int fifo_ptr = 0, n = 0, len = 0, first = 0;
    bit post_chk = 0;
    capture_seq_if #(.size(size)) s_if ();
    capture_seq_if #(.size(size)) m_if ();
    assign s_if.tdata = size'(fifo_ptr);
    assign s_if.tlast = 1'b0;
    capture_seq #(.size(size), .saddr_w(saddr_w), .timeout_w(timeout_w)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .buffer_size(buffer_size),
        .cap_arm(cap_arm), .cap_abort(cap_abort), .cap_armed(cap_armed),
        .cap_triggered(cap_triggered), .cap_done(cap_done), .cap_ready(cap_ready),
        .s(s_if), .m(m_if), .busy(busy), .done_irq(done_irq), .result(result),
        .beat_count(beat_count)
    );
    always #5 clk = ~clk;
    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // FIFO model: words are their own index, popped on every handshake
    always @(posedge clk) if (s_if.tvalid && s_if.tready) fifo_ptr <= fifo_ptr + 1;
    // DMA-side scoreboard: in-order words, tlast exactly on beat len, ready drops after it
    always @(negedge clk) begin
        if (post_chk) begin
            chk("tready_after_last", s_if.tready, 0);
            post_chk = 0;
        end
        if (m_if.tvalid && m_if.tready) begin
            chk("beat_in_range", n < len, 1);
            chk("beat_data", m_if.tdata, first + n);
            chk("beat_tlast", m_if.tlast, n == len - 1);
            if (n == len - 1) post_chk = 1;
            n++;
        end
    end
    task automatic run(int l, int stop_at, int rst_at, int pv, int pr, int dd);
        int cyc = 0;
        bit stopped = 0, coinc = 0;
        len = l; n = 0; first = fifo_ptr;
        buffer_size = saddr_w'(l);
        start = 1;
        tick();
        start = 0;
        chk("arm_pulse", cap_arm, 1);
        chk("run_busy", busy, 1);
        chk("result_cleared", result, 0);
        tick();
        chk("arm_one_cycle", cap_arm, 0);
        repeat ($urandom_range(5)) tick();
        cap_armed = 1;
        repeat ($urandom_range(3, 1)) tick();
        cap_triggered = 1;
        while (!done_irq && !(stopped && !coinc) && cyc < 3000) begin
            if (rst_at > 0 && n >= rst_at) begin
                #2 reset = 0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_result", result, 0);
                chk("rst_beat_count", beat_count, 0);
                chk("rst_m_tvalid", m_if.tvalid, 0);
                chk("rst_s_tready", s_if.tready, 0);
                chk("rst_m_tlast", m_if.tlast, 0);
                chk("rst_pulses", {cap_arm, cap_abort, done_irq}, 0);
                {cap_armed, cap_triggered, cap_done} = 0;
                s_if.tvalid = 0; m_if.tready = 0;
                tick();
                reset = 1;
                tick();
                return;
            end
            s_if.tvalid = ($urandom_range(99) < pv);
            m_if.tready = ($urandom_range(99) < pr);
            if (cyc == dd) cap_done = 1;
            if (stop_at >= 0 && !stopped && n >= stop_at && n < l) begin
                stop = 1;
                stopped = 1;
                coinc = (n == l - 1) && s_if.tvalid && m_if.tready;
            end
            tick();
            stop = 0;
            cyc++;
        end
        if (stopped && !coinc) begin
            chk("abort_pulse", cap_abort, 1);
            s_if.tvalid = 1; m_if.tready = 1;
            tick();
            repeat (3) begin
                #1;
                chk("flush_m_tvalid", m_if.tvalid, 0);
                chk("flush_s_tready", s_if.tready, 1);
                chk("flush_no_irq", done_irq, 0);
                tick();
            end
            s_if.tvalid = 0;
            cyc = 0;
            while (!done_irq && cyc < 20) begin
                tick();
                cyc++;
            end
        end
        chk("run_done_seen", done_irq, 1);
        chk("run_result", result, (stopped && !coinc) ? 2 : 1);
        chk("run_beats", beat_count, (stopped && !coinc) ? n : l);
        s_if.tvalid = 0; m_if.tready = 0;
        {cap_armed, cap_triggered, cap_done} = 0;
        tick();
        chk("irq_one_cycle", done_irq, 0);
        chk("idle_busy", busy, 0);
    endtask
    typedef struct {
        bit st, sp, rdy;
        int sz;
        bit arm, irq;
        int res;
    } vec_t;
    vec_t vt[8];
    initial begin
        int k;
        vt[0] = '{1, 1, 1, 5, 0, 0, 0};
        vt[1] = '{1, 0, 0, 5, 0, 0, 0};
        vt[2] = '{1, 0, 1, 0, 0, 1, 3};
        vt[3] = '{0, 0, 1, 5, 0, 0, 3};
        vt[4] = '{1, 0, 1, 7, 1, 0, 0};
        vt[5] = '{1, 1, 1, 0, 0, 0, 2};
        vt[6] = '{1, 0, 0, 0, 0, 0, 2};
        vt[7] = '{1, 0, 1, 1, 1, 0, 0};
        s_if.tvalid = 0;
        m_if.tready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_beat_count", beat_count, 0);
        chk("reset_pulses", {cap_arm, cap_abort, done_irq}, 0);
        reset = 1;
        tick();
        chk("post_reset_busy", busy, 0);
        foreach (vt[i]) begin
            start = vt[i].st; stop = vt[i].sp; cap_ready = vt[i].rdy;
            buffer_size = saddr_w'(vt[i].sz);
            tick();
            start = 0; stop = 0; cap_ready = 1;
            chk($sformatf("vec%0d_arm", i), cap_arm, vt[i].arm);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].arm);
            chk($sformatf("vec%0d_irq", i), done_irq, vt[i].irq);
            chk($sformatf("vec%0d_result", i), result, vt[i].res);
            if (vt[i].arm) begin
                stop = 1;
                tick();
                stop = 0;
                chk($sformatf("vec%0d_abort", i), cap_abort, 1);
                tick();
                tick();
                chk($sformatf("vec%0d_abort_irq", i), done_irq, 1);
                chk($sformatf("vec%0d_abort_result", i), result, 2);
            end
            tick();
            chk($sformatf("vec%0d_irq_clear", i), done_irq, 0);
        end
        run(128, -1, 0, 100, 100, 200);
        run(128, -1, 0, 100, 50, 300);
        run(128, 40, 0, 100, 100, 100);
        run(16, 15, 0, 100, 100, 100);
        buffer_size = saddr_w'(8);
        start = 1;
        tick();
        start = 0;
        k = 0;
        while (!cap_abort && k < 40) begin
            tick();
            k++;
        end
        chk("timeout_cycles", k, 16);
        tick();
        tick();
        chk("timeout_irq", done_irq, 1);
        chk("timeout_result", result, 3);
        tick();
        run(128, -1, 60, 100, 100, 0);
        chk("after_reset_result", result, 0);
        run(128, -1, 0, 100, 100, 200);
        repeat (20) begin
            int l;
            l = $urandom_range(48, 1);
            run(l, ($urandom_range(1) == 1) ? int'($urandom_range(l - 1)) : -1, 0,
                $urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
